// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller.
//   state_t      : controller states (idle, accumulating credit, dispensing, returning change)
//   COIN_*       : coin acceptor / change hopper codes
//   UNITS_*      : coin values in 5rs credit units
//   coin_units() : coin code to credit units (0 for none or invalid)
package vend_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } state_t;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [1:0] UNITS_5  = 2'd1;
    localparam logic [1:0] UNITS_10 = 2'd2;

    function automatic logic [1:0] coin_units(input logic [1:0] code);
        logic [1:0] units;
        case (code)
            COIN_5:  units = UNITS_5;
            COIN_10: units = UNITS_10;
            default: units = 2'd0;
        endcase
        return units;
    endfunction

endpackage

// File: rtl/vend_change_engine.sv
// Change-return engine: pays out an amount one hopper coin at a time,
// largest coin first.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_start        : begin paying out i_amount (must be non-zero)
//   i_amount       : live credit still owed (owned by the parent)
//   i_chg_ack      : hopper released the requested coin
//   o_chg_req      : coin request to the hopper, held until acknowledged
//   o_chg_coin     : requested coin (COIN_10 or COIN_5)
//   o_remaining    : amount owed after this cycle's acknowledge
//   o_done         : this cycle's acknowledge settles the last unit
module vend_change_engine
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [CREDIT_W-1:0] i_amount,
    input  logic                i_chg_ack,
    output logic                o_chg_req,
    output logic [1:0]          o_chg_coin,
    output logic [CREDIT_W-1:0] o_remaining,
    output logic                o_done
);

    logic                r_active;
    logic                r_req;
    logic [1:0]          r_coin;
    logic                w_ack;
    logic [CREDIT_W-1:0] w_paid;
    logic [1:0]          w_pick;

    // An acknowledge only counts while the request is actually up.
    assign w_ack       = r_req & i_chg_ack;
    assign w_paid      = (r_coin == COIN_10) ? CREDIT_W'(UNITS_10) : CREDIT_W'(UNITS_5);
    assign o_remaining = w_ack ? (i_amount - w_paid) : i_amount;
    assign o_done      = w_ack && (o_remaining == '0);
    assign w_pick      = (i_amount >= CREDIT_W'(UNITS_10)) ? COIN_10 : COIN_5;

    assign o_chg_req   = r_req;
    assign o_chg_coin  = r_coin;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_active <= 1'b0;
            r_req    <= 1'b0;
            r_coin   <= COIN_NONE;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_req    <= 1'b1;
            r_coin   <= w_pick;
        end else if (r_active) begin
            if (w_ack) begin
                // Request drops for one cycle after every acknowledge.
                r_req <= 1'b0;
                if (o_done) begin
                    r_active <= 1'b0;
                    r_coin   <= COIN_NONE;
                end
            end else if (!r_req) begin
                // i_amount already reflects the last coin paid.
                r_req  <= 1'b1;
                r_coin <= w_pick;
            end
        end
    end

endmodule

// File: rtl/vend_sequencer.sv
// Multi-product vending controller: accumulates coin credit, validates
// selections against a price table, sequences dispense and change-return
// handshakes, refunds on cancel or inactivity.
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_coin           : coin code, one cycle per coin (00 none, 01 5rs, 10 10rs, 11 bad)
//   i_sel_valid/_id  : single-cycle selection strobe and item
//   i_cancel         : single-cycle refund request
//   i_disp_ack       : dispenser finished
//   i_chg_ack        : hopper released one coin
//   o_disp_req/_id   : dispense request and item, held until acknowledged
//   o_chg_req/_coin  : change coin request and coin
//   o_coin_reject    : one-cycle pulse, coin returned unaccepted
//   o_short_credit   : one-cycle pulse, selection refused for low credit
//   o_credit         : current credit in 5rs units
//   o_busy           : dispensing or returning change
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NUM_ITEMS   = 4,
    parameter int CREDIT_W    = 4,
    parameter int MAX_CREDIT  = 8,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICE_LIST = {4'd4, 4'd3, 4'd2, 4'd1},
    parameter int TIMEOUT_CYC = 1024,
    localparam int ID_W  = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [1:0]          i_coin,
    input  logic                i_sel_valid,
    input  logic [ID_W-1:0]     i_sel_id,
    input  logic                i_cancel,
    input  logic                i_disp_ack,
    input  logic                i_chg_ack,
    output logic                o_disp_req,
    output logic [ID_W-1:0]     o_disp_id,
    output logic                o_chg_req,
    output logic [1:0]          o_chg_coin,
    output logic                o_coin_reject,
    output logic                o_short_credit,
    output logic [CREDIT_W-1:0] o_credit,
    output logic                o_busy
);

    state_t              r_state,        w_state_next;
    logic [CREDIT_W-1:0] r_credit,       w_credit_next;
    logic [TMR_W-1:0]    r_timer,        w_timer_next;
    logic                r_disp_req,     w_disp_req_next;
    logic [ID_W-1:0]     r_disp_id,      w_disp_id_next;
    logic                r_coin_reject,  w_coin_reject_next;
    logic                r_short_credit, w_short_credit_next;
    logic                r_busy,         w_busy_next;

    logic                w_chg_start;
    logic [CREDIT_W-1:0] w_chg_remaining;
    logic                w_chg_done;

    logic [CREDIT_W-1:0] w_price_tab [NUM_ITEMS];
    logic [CREDIT_W-1:0] w_price;
    logic [1:0]          w_units;
    logic [CREDIT_W:0]   w_sum;
    logic                w_coin_any;
    logic                w_coin_valid;
    logic                w_coin_fits;
    logic                w_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ITEMS; gi++) begin : g_price
            assign w_price_tab[gi] = PRICE_LIST[gi*CREDIT_W +: CREDIT_W];
        end
    endgenerate

    assign w_price      = w_price_tab[i_sel_id];
    assign w_units      = coin_units(i_coin);
    assign w_coin_any   = (i_coin != COIN_NONE);
    assign w_coin_valid = (w_units != 2'd0);
    // One extra bit so an overflowing sum is caught rather than wrapped.
    assign w_sum        = {1'b0, r_credit} + {{(CREDIT_W-1){1'b0}}, w_units};
    assign w_coin_fits  = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));
    assign w_timeout    = (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_comb begin
        w_state_next        = r_state;
        w_credit_next       = r_credit;
        w_timer_next        = '0;
        w_disp_req_next     = r_disp_req;
        w_disp_id_next      = r_disp_id;
        w_coin_reject_next  = 1'b0;
        w_short_credit_next = 1'b0;
        w_chg_start         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_coin_valid) begin
                    w_credit_next = CREDIT_W'(w_units);
                    w_state_next  = ST_CREDIT;
                end else if (w_coin_any) begin
                    w_coin_reject_next = 1'b1;
                end
                if (i_sel_valid) begin
                    w_short_credit_next = 1'b1;
                end
            end

            ST_CREDIT: begin
                w_timer_next = r_timer + TMR_W'(1);
                if (i_cancel) begin
                    w_timer_next       = '0;
                    w_coin_reject_next = w_coin_any;
                    if (r_credit == '0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_chg_start  = 1'b1;
                        w_state_next = ST_CHANGE;
                    end
                end else if (i_sel_valid) begin
                    w_timer_next       = '0;
                    w_coin_reject_next = w_coin_any;
                    if (r_credit >= w_price) begin
                        w_credit_next   = r_credit - w_price;
                        w_disp_id_next  = i_sel_id;
                        w_disp_req_next = 1'b1;
                        w_state_next    = ST_VEND;
                    end else begin
                        w_short_credit_next = 1'b1;
                    end
                end else if (w_coin_any) begin
                    w_timer_next = '0;
                    if (w_coin_valid && w_coin_fits) begin
                        w_credit_next = w_sum[CREDIT_W-1:0];
                    end else begin
                        w_coin_reject_next = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_timer_next = '0;
                    if (r_credit == '0) begin
                        w_state_next = ST_IDLE;
                    end else begin
                        w_chg_start  = 1'b1;
                        w_state_next = ST_CHANGE;
                    end
                end
            end

            ST_VEND: begin
                w_coin_reject_next = w_coin_any;
                if (i_disp_ack && r_disp_req) begin
                    w_disp_req_next = 1'b0;
                    if (r_credit != '0) begin
                        w_chg_start  = 1'b1;
                        w_state_next = ST_CHANGE;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end
            end

            ST_CHANGE: begin
                w_coin_reject_next = w_coin_any;
                w_credit_next      = w_chg_remaining;
                if (w_chg_done) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next == ST_VEND) || (w_state_next == ST_CHANGE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_credit       <= '0;
            r_timer        <= '0;
            r_disp_req     <= 1'b0;
            r_disp_id      <= '0;
            r_coin_reject  <= 1'b0;
            r_short_credit <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_credit       <= w_credit_next;
            r_timer        <= w_timer_next;
            r_disp_req     <= w_disp_req_next;
            r_disp_id      <= w_disp_id_next;
            r_coin_reject  <= w_coin_reject_next;
            r_short_credit <= w_short_credit_next;
            r_busy         <= w_busy_next;
        end
    end

    vend_change_engine #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (w_chg_start),
        .i_amount    (r_credit),
        .i_chg_ack   (i_chg_ack),
        .o_chg_req   (o_chg_req),
        .o_chg_coin  (o_chg_coin),
        .o_remaining (w_chg_remaining),
        .o_done      (w_chg_done)
    );

    assign o_disp_req     = r_disp_req;
    assign o_disp_id      = r_disp_id;
    assign o_coin_reject  = r_coin_reject;
    assign o_short_credit = r_short_credit;
    assign o_credit       = r_credit;
    assign o_busy         = r_busy;

endmodule

// File: tb/tb_vend_sequencer.sv
module tb_vend_sequencer;

    localparam int TB_TIMEOUT = 32;
    localparam int TB_MAX     = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] i_coin;
    logic       i_sel_valid;
    logic [1:0] i_sel_id;
    logic       i_cancel;
    logic       i_disp_ack;
    logic       i_chg_ack;
    logic       o_disp_req;
    logic [1:0] o_disp_id;
    logic       o_chg_req;
    logic [1:0] o_chg_coin;
    logic       o_coin_reject;
    logic       o_short_credit;
    logic [3:0] o_credit;
    logic       o_busy;

    always #5 clk = ~clk;

    vend_sequencer #(
        .TIMEOUT_CYC (TB_TIMEOUT)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_coin         (i_coin),
        .i_sel_valid    (i_sel_valid),
        .i_sel_id       (i_sel_id),
        .i_cancel       (i_cancel),
        .i_disp_ack     (i_disp_ack),
        .i_chg_ack      (i_chg_ack),
        .o_disp_req     (o_disp_req),
        .o_disp_id      (o_disp_id),
        .o_chg_req      (o_chg_req),
        .o_chg_coin     (o_chg_coin),
        .o_coin_reject  (o_coin_reject),
        .o_short_credit (o_short_credit),
        .o_credit       (o_credit),
        .o_busy         (o_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int n_step = 0;

    // ---------------- behavioural reference model ----------------
    int price [4] = '{1, 2, 3, 4};
    int m_credit, m_idle, m_disp_id, m_chg_val;
    bit m_session, m_vending, m_refund, m_disp_req, m_chg_req, m_rej, m_short;

    function automatic int units(input int c);
        return (c == 1) ? 1 : (c == 2) ? 2 : 0;
    endfunction

    task automatic model_reset();
        m_credit = 0; m_idle = 0; m_disp_id = 0; m_chg_val = 0;
        m_session = 0; m_vending = 0; m_refund = 0;
        m_disp_req = 0; m_chg_req = 0; m_rej = 0; m_short = 0;
    endtask

    task automatic refund_or_idle();
        m_session = 0;
        if (m_credit > 0) begin
            m_refund  = 1;
            m_chg_req = 1;
            m_chg_val = (m_credit >= 2) ? 2 : 1;
        end
    endtask

    task automatic model_clock(input int c, input int sv, input int sid,
                               input int can, input int dack, input int cack);
        m_rej = 0;
        m_short = 0;
        if (m_refund) begin
            if (c != 0) m_rej = 1;
            if (m_chg_req && cack != 0) begin
                m_credit -= m_chg_val;
                m_chg_req = 0;
                if (m_credit == 0) m_refund = 0;
            end else if (!m_chg_req) begin
                m_chg_req = 1;
                m_chg_val = (m_credit >= 2) ? 2 : 1;
            end
        end else if (m_vending) begin
            if (c != 0) m_rej = 1;
            if (dack != 0) begin
                m_vending = 0;
                m_disp_req = 0;
                refund_or_idle();
            end
        end else if (m_session) begin
            if (can != 0) begin
                if (c != 0) m_rej = 1;
                m_idle = 0;
                refund_or_idle();
            end else if (sv != 0) begin
                if (c != 0) m_rej = 1;
                m_idle = 0;
                if (m_credit >= price[sid]) begin
                    m_credit  -= price[sid];
                    m_disp_id  = sid;
                    m_disp_req = 1;
                    m_vending  = 1;
                    m_session  = 0;
                end else begin
                    m_short = 1;
                end
            end else if (c != 0) begin
                m_idle = 0;
                if (units(c) != 0 && m_credit + units(c) <= TB_MAX) m_credit += units(c);
                else m_rej = 1;
            end else if (m_idle == TB_TIMEOUT - 1) begin
                m_idle = 0;
                refund_or_idle();
            end else begin
                m_idle++;
            end
        end else begin
            if (c == 3) m_rej = 1;
            else if (c != 0) begin
                m_credit = units(c);
                m_session = 1;
                m_idle = 0;
            end
            if (sv != 0) m_short = 1;
        end
    endtask

    task automatic check_model();
        int  e_coin;
        bit  bad;
        e_coin = (m_chg_val == 2) ? 2 : 1;
        bad = (int'(o_credit) != m_credit) || (o_disp_req != m_disp_req) ||
              (m_disp_req && int'(o_disp_id) != m_disp_id) ||
              (o_chg_req != m_chg_req) || (m_chg_req && int'(o_chg_coin) != e_coin) ||
              (o_coin_reject != m_rej) || (o_short_credit != m_short) ||
              (o_busy != (m_vending || m_refund));
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL model step %0d: got credit=%0d dreq=%b did=%0d creq=%b coin=%0d rej=%b short=%b busy=%b; required credit=%0d dreq=%b did=%0d creq=%b coin=%0d rej=%b short=%b busy=%b",
                     n_step, o_credit, o_disp_req, o_disp_id, o_chg_req, o_chg_coin,
                     o_coin_reject, o_short_credit, o_busy, m_credit, m_disp_req, m_disp_id,
                     m_chg_req, e_coin, m_rej, m_short, m_vending || m_refund);
        end
    endtask

    // One clock of stimulus; the model follows the same inputs and checks.
    task automatic step(input int c, input int sv, input int sid,
                        input int can, input int dack, input int cack);
        @(negedge clk);
        i_coin      = 2'(c);
        i_sel_valid = (sv != 0);
        i_sel_id    = 2'(sid);
        i_cancel    = (can != 0);
        i_disp_ack  = (dack != 0);
        i_chg_ack   = (cack != 0);
        @(posedge clk);
        n_step++;
        if (rst_n) model_clock(c, sv, sid, can, dack, cack);
        #1;
        check_model();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_zero(input string name);
        n_cmp++;
        if ({o_disp_req, o_disp_id, o_chg_req, o_chg_coin, o_coin_reject,
             o_short_credit, o_credit, o_busy} != '0) begin
            n_bad++;
            $display("FAIL %s: got dreq=%b did=%0d creq=%b coin=%0d rej=%b short=%b credit=%0d busy=%b, required all zero",
                     name, o_disp_req, o_disp_id, o_chg_req, o_chg_coin,
                     o_coin_reject, o_short_credit, o_credit, o_busy);
        end
    endtask

    task automatic check_val(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int coin, sv, sid, can, dack, cack;
        int e_credit, e_dreq, e_did, e_creq, e_coin, e_rej, e_short, e_busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int coin, sv, sid, can, dack, cack,
                                 e_credit, e_dreq, e_did, e_creq, e_coin,
                                 e_rej, e_short, e_busy);
        vec_t v;
        v.coin = coin; v.sv = sv; v.sid = sid; v.can = can; v.dack = dack; v.cack = cack;
        v.e_credit = e_credit; v.e_dreq = e_dreq; v.e_did = e_did; v.e_creq = e_creq;
        v.e_coin = e_coin; v.e_rej = e_rej; v.e_short = e_short; v.e_busy = e_busy;
        return v;
    endfunction

    initial begin : wdog
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int k;
        int found;

        rst_n = 1'b0;
        i_coin = 0; i_sel_valid = 0; i_sel_id = 0; i_cancel = 0; i_disp_ack = 0; i_chg_ack = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset_state");
        @(negedge clk);
        rst_n = 1'b1;

        //               coin sv sid can dak cak | cred dreq did creq coin rej sht busy
        // purchase with change (stray chg_ack during VEND is ignored)
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2, 0, 0, 0,   1, 1, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   1, 1, 2, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        // idle: selection refused, cancel ignored, bad coin rejected
        vecs.push_back(mk(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 1, 0, 0));
        // short credit then cancel
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 3, 0, 0, 0,   1, 0, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   1, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        // overflow, invalid coin, four 10rs refunds
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   4, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   8, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(3, 0, 0, 0, 0, 0,   8, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0,   8, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   6, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   6, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   4, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   4, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0,   2, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        // simultaneous events
        vecs.push_back(mk(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, 1, 1, 0, 0, 0,   1, 1, 1, 0, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,   2, 0, 0, 1, 2, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            bit   bad;
            v = vecs[i];
            step(v.coin, v.sv, v.sid, v.can, v.dack, v.cack);
            bad = (int'(o_credit) != v.e_credit) || (int'(o_disp_req) != v.e_dreq) ||
                  (v.e_dreq != 0 && int'(o_disp_id) != v.e_did) ||
                  (int'(o_chg_req) != v.e_creq) || (v.e_creq != 0 && int'(o_chg_coin) != v.e_coin) ||
                  (int'(o_coin_reject) != v.e_rej) || (int'(o_short_credit) != v.e_short) ||
                  (int'(o_busy) != v.e_busy);
            n_cmp++;
            $display("vec %0d: coin=%0d sel=%0d/%0d cancel=%0d dack=%0d cack=%0d -> credit=%0d dreq=%b creq=%b coin=%0d rej=%b short=%b busy=%b",
                     i, v.coin, v.sv, v.sid, v.can, v.dack, v.cack, o_credit, o_disp_req,
                     o_chg_req, o_chg_coin, o_coin_reject, o_short_credit, o_busy);
            if (bad) begin
                n_bad++;
                $display("FAIL vec %0d: got credit=%0d dreq=%b did=%0d creq=%b coin=%0d rej=%b short=%b busy=%b; required credit=%0d dreq=%0d did=%0d creq=%0d coin=%0d rej=%0d short=%0d busy=%0d",
                         i, o_credit, o_disp_req, o_disp_id, o_chg_req, o_chg_coin, o_coin_reject,
                         o_short_credit, o_busy, v.e_credit, v.e_dreq, v.e_did, v.e_creq,
                         v.e_coin, v.e_rej, v.e_short, v.e_busy);
            end
        end

        // timeout: credit 3, then quiet until the refund starts
        step(1, 0, 0, 0, 0, 0);
        step(2, 0, 0, 0, 0, 0);
        found = 0;
        for (k = 1; k <= TB_TIMEOUT + 4; k++) begin
            idle();
            if (o_chg_req) begin
                found = k;
                break;
            end
        end
        $display("timeout: refund started after %0d idle cycles", found);
        check_val("timeout_cycles", found, TB_TIMEOUT);
        check_val("timeout_first_coin", int'(o_chg_coin), 2);
        step(1, 0, 0, 0, 0, 0);
        check_val("coin_in_change_rejected", int'(o_coin_reject), 1);
        step(0, 0, 0, 0, 0, 1);
        check_val("timeout_credit_after_10", int'(o_credit), 1);
        idle();
        check_val("timeout_second_coin", int'(o_chg_coin), 1);
        step(0, 0, 0, 0, 0, 1);
        check_val("timeout_back_idle", int'(o_busy), 0);

        // asynchronous reset while a dispense is outstanding
        step(2, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0);
        check_val("pre_reset_disp_req", int'(o_disp_req), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_zero("async_reset_mid_vend");
        model_reset();
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 0, 0, 0, 0, 0);
        check_val("after_reset_credit", int'(o_credit), 1);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            int r, c;
            r = $urandom_range(0, 99);
            c = (r < 15) ? 1 : (r < 25) ? 2 : (r < 28) ? 3 : 0;
            if ($urandom_range(0, 199) == 0) begin
                repeat (TB_TIMEOUT + 2) idle();
            end else begin
                step(c, ($urandom_range(0, 99) < 10) ? 1 : 0, $urandom_range(0, 3),
                     ($urandom_range(0, 99) < 4) ? 1 : 0,
                     ($urandom_range(0, 99) < 35) ? 1 : 0,
                     ($urandom_range(0, 99) < 35) ? 1 : 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
